// File: rtl/sdram_port_arbiter_if.sv
// SDRAM command/response channel between the port arbiter (master) and the SDRAM controller (slave).
interface sdram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] sdram_addr;
    logic [DATA_W-1:0] sdram_wdata;
    logic              sdram_we;
    logic              sdram_re;
    logic              sdram_ready;
    logic [DATA_W-1:0] sdram_rdata;
    logic              sdram_rvalid;

    modport master (
        output sdram_addr, sdram_wdata, sdram_we, sdram_re,
        input  sdram_ready, sdram_rdata, sdram_rvalid
    );

    modport slave (
        input  sdram_addr, sdram_wdata, sdram_we, sdram_re,
        output sdram_ready, sdram_rdata, sdram_rvalid
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM command port between the scene loader write FIFO and NUM_RD round-robin readers.
// Define SCENE_LOAD_LOCK_EN to hold off all reads until the scene load has drained (LOAD -> RUN FSM).
module sdram_port_arbiter #(
    parameter int unsigned NUM_RD      = 4,
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WFIFO_DEPTH = 8,
    parameter int unsigned MAX_OUTST   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        sl_addr,
    input  logic [DATA_W-1:0]        sl_io,
    input  logic                     sl_we,
    input  logic                     sl_done,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_gnt,
    output logic [DATA_W-1:0]        rd_data,
    output logic [NUM_RD-1:0]        rd_data_valid,
    sdram_port_arbiter_if.master     sdram,
    output logic                     wfifo_overflow,
    output logic                     rsp_err
);
    localparam int unsigned IDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int unsigned WP_W  = $clog2(WFIFO_DEPTH);
    localparam int unsigned OP_W  = $clog2(MAX_OUTST);

    // Command register
    logic              r_cmd_we;
    logic              r_cmd_re;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;
    logic [IDX_W-1:0]  r_cmd_id;

    // Write FIFO
    logic [ADDR_W+DATA_W-1:0] r_wf_mem [WFIFO_DEPTH];
    logic [WP_W-1:0]          r_wf_wptr;
    logic [WP_W-1:0]          r_wf_rptr;
    logic [WP_W:0]            r_wf_cnt;

    // ID FIFO
    logic [IDX_W-1:0] r_id_mem [MAX_OUTST];
    logic [OP_W-1:0]  r_id_wptr;
    logic [OP_W-1:0]  r_id_rptr;
    logic [OP_W:0]    r_id_cnt;

    logic [IDX_W-1:0]  r_rr_ptr;
    logic [DATA_W-1:0] r_rd_data;
    logic [NUM_RD-1:0] r_rd_valid;
    logic              r_ovf;
    logic              r_rsp_err;

    logic              w_acc_we;
    logic              w_acc_re;
    logic              w_cmd_free;
    logic              w_wf_empty;
    logic              w_wf_full;
    logic [WP_W:0]     w_wf_occ;
    logic              w_wf_push;
    logic              w_wf_pop;
    logic              w_id_pop;
    logic [OP_W:0]     w_id_next;
    logic              w_run;
    logic              w_rd_ok;
    logic [IDX_W-1:0]  w_rr_start;
    logic [NUM_RD-1:0] w_gnt;
    logic [NUM_RD-1:0] w_elig;
    logic [NUM_RD-1:0] w_rsp_vec;
    logic              w_found;
    logic [IDX_W-1:0]  w_sel;
    logic [ADDR_W-1:0] w_sel_addr;
    int unsigned       w_dist;
    int unsigned       w_best;

    function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] v);
        return (32'(v) == NUM_RD - 1) ? '0 : v + 1'b1;
    endfunction

`ifdef SCENE_LOAD_LOCK_EN
    typedef enum logic {ST_LOAD, ST_RUN} state_t;
    state_t r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD: if (sl_done && w_wf_empty && !r_cmd_we) r_state <= ST_RUN;
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign w_run = (r_state == ST_RUN);
`else
    logic w_unused_sl_done;
    assign w_unused_sl_done = sl_done;
    assign w_run            = 1'b1;
`endif

    assign w_acc_we   = r_cmd_we & sdram.sdram_ready;
    assign w_acc_re   = r_cmd_re & sdram.sdram_ready;
    assign w_cmd_free = ~(r_cmd_we | r_cmd_re) | w_acc_we | w_acc_re;

    // The write held in the command register still occupies a FIFO slot until accepted.
    assign w_wf_empty = (r_wf_cnt == '0);
    assign w_wf_occ   = r_wf_cnt + (WP_W+1)'(r_cmd_we);
    assign w_wf_full  = (w_wf_occ == (WP_W+1)'(WFIFO_DEPTH));
    assign w_wf_push  = sl_we & (~w_wf_full | w_acc_we);
    assign w_wf_pop   = w_cmd_free & ~w_wf_empty;

    assign w_id_pop   = sdram.sdram_rvalid & (r_id_cnt != '0);
    assign w_id_next  = r_id_cnt + (OP_W+1)'(w_acc_re) - (OP_W+1)'(w_id_pop);
    assign w_rd_ok    = w_run & (w_id_next < (OP_W+1)'(MAX_OUTST));
    assign w_rr_start = w_acc_re ? f_inc(r_cmd_id) : r_rr_ptr;

    always_comb begin
        w_gnt     = '0;
        w_rsp_vec = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            w_gnt[i]     = w_acc_re & (r_cmd_id == IDX_W'(i));
            w_rsp_vec[i] = w_id_pop & (r_id_mem[r_id_rptr] == IDX_W'(i));
        end
    end

    // The requester being granted this cycle still shows rd_req high; mask it from the next pick.
    assign w_elig = rd_req & ~w_gnt & {NUM_RD{w_rd_ok}};

    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_sel_addr = '0;
        w_best     = NUM_RD;
        w_dist     = 0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            w_dist = (i + NUM_RD - 32'(w_rr_start)) % NUM_RD;
            if (w_elig[i] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_found    = 1'b1;
                w_sel      = IDX_W'(i);
                w_sel_addr = rd_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd_we    <= 1'b0;
            r_cmd_re    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_cmd_id    <= '0;
            r_wf_wptr   <= '0;
            r_wf_rptr   <= '0;
            r_wf_cnt    <= '0;
            r_id_wptr   <= '0;
            r_id_rptr   <= '0;
            r_id_cnt    <= '0;
            r_rr_ptr    <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= '0;
            r_ovf       <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_cmd_free) begin
                if (!w_wf_empty) begin
                    r_cmd_we                  <= 1'b1;
                    r_cmd_re                  <= 1'b0;
                    {r_cmd_addr, r_cmd_wdata} <= r_wf_mem[r_wf_rptr];
                end else if (w_found) begin
                    r_cmd_we   <= 1'b0;
                    r_cmd_re   <= 1'b1;
                    r_cmd_addr <= w_sel_addr;
                    r_cmd_id   <= w_sel;
                end else begin
                    r_cmd_we <= 1'b0;
                    r_cmd_re <= 1'b0;
                end
            end
            if (w_wf_push) r_wf_wptr <= r_wf_wptr + 1'b1;
            if (w_wf_pop)  r_wf_rptr <= r_wf_rptr + 1'b1;
            r_wf_cnt <= r_wf_cnt + (WP_W+1)'(w_wf_push) - (WP_W+1)'(w_wf_pop);
            if (sl_we && !w_wf_push) r_ovf <= 1'b1;

            if (w_acc_re) begin
                r_id_wptr <= r_id_wptr + 1'b1;
                r_rr_ptr  <= f_inc(r_cmd_id);
            end
            if (w_id_pop) r_id_rptr <= r_id_rptr + 1'b1;
            r_id_cnt   <= w_id_next;
            r_rd_valid <= w_rsp_vec;
            if (sdram.sdram_rvalid) r_rd_data <= sdram.sdram_rdata;
            if (sdram.sdram_rvalid && !w_id_pop) r_rsp_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wf_push) r_wf_mem[r_wf_wptr] <= {sl_addr, sl_io};
        if (w_acc_re)  r_id_mem[r_id_wptr] <= r_cmd_id;
    end

    assign sdram.sdram_addr  = r_cmd_addr;
    assign sdram.sdram_wdata = r_cmd_wdata;
    assign sdram.sdram_we    = r_cmd_we;
    assign sdram.sdram_re    = r_cmd_re;
    assign rd_gnt            = w_gnt;
    assign rd_data           = r_rd_data;
    assign rd_data_valid     = r_rd_valid;
    assign wfifo_overflow    = r_ovf;
    assign rsp_err           = r_rsp_err;
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM command port between the scene loader's write stream and NUM_RD read requesters (kd-tree, list, triangle and shader caches).
- Absorbs the loader's unthrottled one-cycle write pulses in a write FIFO; writes have priority over reads.
- Reads are granted round-robin. Read data returns in order and is steered back to the requester that issued it via an ID FIFO.

Parameters:
NUM_RD, 4, number of read requesters
ADDR_W, 25, SDRAM word address width
DATA_W, 32, SDRAM data width
WFIFO_DEPTH, 8, loader write FIFO entries (power of 2)
MAX_OUTST, 8, maximum outstanding reads; also the ID FIFO depth (power of 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
sl_addr  in  ADDR_W  loader write address
sl_io  in  DATA_W  loader write data
sl_we  in  1  loader write strobe, one cycle per word, no backpressure
sl_done  in  1  loader finished (level)
rd_req  in  NUM_RD  per-requester read request (level, held until granted)
rd_addr  in  NUM_RD*ADDR_W  per-requester address; requester i occupies bits [i*ADDR_W +: ADDR_W]
rd_gnt  out  NUM_RD  one-hot pulse: request accepted by SDRAM
rd_data  out  DATA_W  returned read data
rd_data_valid  out  NUM_RD  one-hot pulse: rd_data belongs to requester i
sdram_addr  out  ADDR_W  command address
sdram_wdata  out  DATA_W  write data
sdram_we  out  1  write command valid
sdram_re  out  1  read command valid
sdram_ready  in  1  controller accepts the command this cycle
sdram_rdata  in  DATA_W  read data
sdram_rvalid  in  1  read data valid (in issue order)
wfifo_overflow  out  1  sticky: a loader write was dropped
rsp_err  out  1  sticky: sdram_rvalid arrived with the ID FIFO empty

Behaviour:
- Reset (rst low, async): all outputs 0. FIFOs are emptied, the RR pointer is set to 0 and the FSM enters LOAD.
- Command handshake:
  - sdram_addr, sdram_wdata, sdram_we and sdram_re are registered.
  - At most one of sdram_we and sdram_re is high in any cycle.
  - A command is accepted on a cycle where (we|re) & sdram_ready. Until then it holds stable.
  - The next command may be presented the cycle after acceptance. Sustained throughput is 1 command per cycle.
- Write FIFO:
  - Push on sl_we. Pop when the write command is accepted.
  - Push while full: the word is dropped and wfifo_overflow is set. A same-cycle pop counts, so push+pop while full is legal and drops nothing.
  - Writes are issued in FIFO order.
- Priority: when the command register is free, a non-empty write FIFO always wins over reads.
- Read arbitration:
  - Eligible requesters are rd_req bits, provided the outstanding count < MAX_OUTST and the FSM is in RUN.
  - Round-robin search starts at rr_ptr. On acceptance of requester i, rr_ptr becomes (i+1) mod NUM_RD.
  - rd_gnt[i] pulses exactly in the acceptance cycle. The requester may drop rd_req or change rd_addr the following cycle.
- ID FIFO:
  - Push the granted index on read acceptance. Pop on sdram_rvalid.
  - Outstanding count is 0..MAX_OUTST. Push+pop in the same cycle leaves the count unchanged.
- Response path:
  - rd_data = sdram_rdata registered. rd_data_valid[id] is asserted 1 cycle after sdram_rvalid.
  - sdram_rvalid with the ID FIFO empty: no valid output is driven and rsp_err is set.
- FSM:
  - LOAD -> RUN when sl_done=1 and the write FIFO is empty and no write command is pending.
  - RUN -> LOAD never, except via reset.
  - In RUN, sl_we is still accepted (writes keep priority).
- Reset asserted mid-transaction drops all pending commands and in-flight IDs. The SDRAM controller is reset concurrently.

Optional Feature:
SCENE_LOAD_LOCK_EN
- Defined: reads are blocked in LOAD as described above.
- Undefined: the FSM is removed and reads are eligible from reset. Write priority is unchanged, so reads interleave only in cycles where the write FIFO is empty.

Test Plan:
- Load lock (macro on): 16 sl_we pulses at addr 0x10..0x1F with sdram_ready=1, rd_req=4'b0001 held, sl_done raised after the last write -> 16 writes in order, then rd_gnt[0] no earlier than the cycle after the last write is accepted.
- Backpressure: sdram_ready=0 for 20 cycles while 9 sl_we pulses arrive (depth 8) -> wfifo_overflow=1; the 9th word is absent; 8 writes issue in order once ready=1.
- Round-robin: in RUN, rd_req=4'b1111 held, ready=1 -> grant order 0,1,2,3,0.
- Outstanding limit: no rvalid, continuous requests -> exactly 8 grants, then sdram_re stays 0. One rvalid -> rd_data_valid pulses for the first ID and a 9th grant follows.
- Response steering: grants to 2 then 0; rvalid with data 0xAAAA then 0x5555 -> rd_data_valid=4'b0100 with 0xAAAA, then 4'b0001 with 0x5555.
- Spurious response: rvalid with no outstanding reads -> rsp_err=1, rd_data_valid stays 0.
